video_timing_gen: RTL and testbench

- Raster timing generator that drives the pixel-domain inputs of the DVI transmitter: den, hsync, vsync, plus the current pixel coordinates for the pattern or pixel source.
- Runs on the pixel clock, downstream of the PLL and the reset synchroniser, upstream of the pattern source and the DVI transmitter.
- Fully parameterised raster; defaults are 1280x720p60 at 74.25 MHz.

---
 rtl/video_timing_pkg.sv | 25 ++
 rtl/video_timing_if.sv | 27 ++
 rtl/video_timing_gen_axis_counter.sv | 42 ++++
 rtl/video_timing_gen.sv | 96 +++++++++
 tb/tb_video_timing_gen.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// Shared raster timing constants for the pixel-clock video pipeline.
// Holds per-axis timing sets for the supported modes and the sync polarity levels.
package video_timing_pkg;

  localparam bit SYNC_POS = 1'b1;
  localparam bit SYNC_NEG = 1'b0;

  // One axis of a raster: active region, front porch, sync width, back porch, sync level.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    bit          pol;
  } axis_timing_t;

  // 1280x720p60 at 74.25 MHz.
  localparam axis_timing_t H_720P60 = '{active: 1280, fp: 110, sync: 40, bp: 220, pol: SYNC_POS};
  localparam axis_timing_t V_720P60 = '{active: 720,  fp: 5,   sync: 5,  bp: 20,  pol: SYNC_POS};

  // 640x480p60 at 25.175 MHz.
  localparam axis_timing_t H_640X480P60 = '{active: 640, fp: 16, sync: 96, bp: 48, pol: SYNC_NEG};
  localparam axis_timing_t V_640X480P60 = '{active: 480, fp: 10, sync: 2,  bp: 33, pol: SYNC_NEG};

endpackage

// File: rtl/video_timing_if.sv
// Pixel-domain timing bundle between the timing generator and its consumers
// (pattern source, DVI transmitter). The consumer owns the advance enable.
interface video_timing_if #(
  parameter int HW = 11,
  parameter int VW = 10
);

  logic          en;
  logic          den;
  logic          hsync;
  logic          vsync;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output den, hsync, vsync, x, y, line_start, frame_start
  );

  modport slave (
    output en,
    input  den, hsync, vsync, x, y, line_start, frame_start
  );

endinterface

// File: rtl/video_timing_gen_axis_counter.sv
// One raster axis: a wrapping position counter plus combinational decode of
// the active region and the sync window. Used once for h and once for v.
module video_axis_counter #(
  parameter int unsigned ACTIVE = 1280,
  parameter int unsigned FP     = 110,
  parameter int unsigned SYNC   = 40,
  parameter int unsigned BP     = 220,
  parameter bit          POL    = 1'b1,
  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
  localparam int          W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         step,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  // Position advances only when stepped and returns to zero after the last back-porch slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

  // Region decode of the current position; the caller registers these.
  always_comb begin
    wrap   = (cnt == LAST);
    active = (cnt < ACTIVE_END);
    sync   = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? POL : ~POL;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI transmitter's pixel-domain inputs.
// Two axis counters set the raster position; all outputs are a registered
// decode of that position, so they trail the counters by one enabled clock.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_720P60.active,
  parameter int unsigned H_FP     = H_720P60.fp,
  parameter int unsigned H_SYNC   = H_720P60.sync,
  parameter int unsigned H_BP     = H_720P60.bp,
  parameter int unsigned V_ACTIVE = V_720P60.active,
  parameter int unsigned V_FP     = V_720P60.fp,
  parameter int unsigned V_SYNC   = V_720P60.sync,
  parameter int unsigned V_BP     = V_720P60.bp,
  parameter bit          HS_POL   = H_720P60.pol,
  parameter bit          VS_POL   = V_720P60.pol
) (
  input  logic           clk,
  input  logic           resetn,
  video_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          HW      = $clog2(H_TOTAL);
  localparam int          VW      = $clog2(V_TOTAL);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || HW > 16) begin : g_param_check
    $error("video_timing_gen: every timing parameter must be nonzero and the h counter at most 16 bits");
  end

  logic [HW-1:0] h_cnt;
  logic          h_wrap;
  logic          h_active;
  logic          h_sync;
  logic [VW-1:0] v_cnt;
  logic          v_active;
  logic          v_sync;

  video_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL)
  ) u_h_axis (
    .clk    (clk),
    .resetn (resetn),
    .step   (vid.en),
    .cnt    (h_cnt),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  // The line counter only moves on the last pixel slot of a line, so vsync
  // edges always line up with the start of a line.
  video_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL)
  ) u_v_axis (
    .clk    (clk),
    .resetn (resetn),
    .step   (vid.en & h_wrap),
    .cnt    (v_cnt),
    .wrap   (),
    .active (v_active),
    .sync   (v_sync)
  );

  // Register the decoded position; while en is low everything, pulses included, holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vid.den         <= 1'b0;
      vid.hsync       <= ~HS_POL;
      vid.vsync       <= ~VS_POL;
      vid.x           <= '0;
      vid.y           <= '0;
      vid.line_start  <= 1'b0;
      vid.frame_start <= 1'b0;
    end else if (vid.en) begin
      vid.den         <= h_active && v_active;
      vid.hsync       <= h_sync;
      vid.vsync       <= v_sync;
      vid.x           <= h_cnt;
      vid.y           <= v_cnt;
      vid.line_start  <= (h_cnt == '0);
      vid.frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a 720p instance, a tiny 8x6 raster and the
// same tiny raster with negative sync polarity, all driven from one enable
// and one reset and compared with a position-arithmetic reference model.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  typedef struct packed {
    logic        den;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  typedef struct packed {
    logic en;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   k = 0;

  always #5 clk = ~clk;

  video_timing_if #(.HW(11), .VW(10)) if_720 ();
  video_timing_if #(.HW(3),  .VW(3))  if_s ();
  video_timing_if #(.HW(3),  .VW(3))  if_n ();

  assign if_720.en = en;
  assign if_s.en   = en;
  assign if_n.en   = en;

  video_timing_gen dut_720 (.clk(clk), .resetn(resetn), .vid(if_720.master));

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(SYNC_POS), .VS_POL(SYNC_POS)
  ) dut_s (.clk(clk), .resetn(resetn), .vid(if_s.master));

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(SYNC_NEG), .VS_POL(SYNC_NEG)
  ) dut_n (.clk(clk), .resetn(resetn), .vid(if_n.master));

  // Expected outputs after kk enabled edges since reset: the outputs show raster position kk-1.
  function automatic exp_t ref_model(input int ha, hfp, hsw, hbp, va, vfp, vsw, vbp,
                                     input bit hpol, vpol, input int kk);
    exp_t r;
    int ht, vt, h, v;
    r = '0;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (kk == 0) begin
      r.hs = ~hpol;
      r.vs = ~vpol;
      return r;
    end
    h = (kk - 1) % ht;
    v = ((kk - 1) / ht) % vt;
    r.den = (h < ha) && (v < va);
    r.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
    r.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
    r.ls  = (h == 0);
    r.fs  = (h == 0) && (v == 0);
    r.x   = 16'(h);
    r.y   = 16'(v);
    return r;
  endfunction

  function automatic exp_t mkExp(input logic den, hs, vs, ls, fs, input int x, y);
    exp_t r;
    r.den = den; r.hs = hs; r.vs = vs; r.ls = ls; r.fs = fs;
    r.x = 16'(x); r.y = 16'(y);
    return r;
  endfunction

  function automatic vec_t mkVec(input logic e, den, hs, vs, ls, fs, input int x, y);
    vec_t r;
    r.en = e;
    r.e  = mkExp(den, hs, vs, ls, fs, x, y);
    return r;
  endfunction

  function automatic exp_t get720();
    exp_t r;
    r.den = if_720.den; r.hs = if_720.hsync; r.vs = if_720.vsync;
    r.ls = if_720.line_start; r.fs = if_720.frame_start;
    r.x = 16'(if_720.x); r.y = 16'(if_720.y);
    return r;
  endfunction

  function automatic exp_t getS();
    exp_t r;
    r.den = if_s.den; r.hs = if_s.hsync; r.vs = if_s.vsync;
    r.ls = if_s.line_start; r.fs = if_s.frame_start;
    r.x = 16'(if_s.x); r.y = 16'(if_s.y);
    return r;
  endfunction

  function automatic exp_t getN();
    exp_t r;
    r.den = if_n.den; r.hs = if_n.hsync; r.vs = if_n.vsync;
    r.ls = if_n.line_start; r.fs = if_n.frame_start;
    r.x = 16'(if_n.x); r.y = 16'(if_n.y);
    return r;
  endfunction

  task automatic checkOutput(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s k=%0d: got den=%b hs=%b vs=%b ls=%b fs=%b x=%0d y=%0d, expected den=%b hs=%b vs=%b ls=%b fs=%b x=%0d y=%0d",
               name, k, act.den, act.hs, act.vs, act.ls, act.fs, act.x, act.y,
               exp.den, exp.hs, exp.vs, exp.ls, exp.fs, exp.x, exp.y);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "_720"},   get720(), ref_model(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1, k));
    checkOutput({tag, "_small"}, getS(),   ref_model(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1, k));
    checkOutput({tag, "_neg"},   getN(),   ref_model(4, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0, k));
  endtask

  // Drive en on the falling edge, then sample just after the following rising edge.
  task automatic applyStimulus(input logic en_v);
    @(negedge clk);
    en = en_v;
    @(posedge clk);
    #1;
    if (en_v) k++;
  endtask

  task automatic doReset();
    @(negedge clk);
    resetn = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    k = 0;
  endtask

  // Pull reset mid-cycle, check the outputs clear without a clock edge, release on the next falling edge.
  task automatic asyncReset(input string tag);
    #2;
    resetn = 1'b0;
    #1;
    k = 0;
    checkAll(tag);
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[12];
    exp_t e_n;
    int den_cnt, hs_pulses, fs_cnt, vs_high, vs_first, n_hs_low, n_vs_low, hs_720;
    logic prev_hs;

    vecs[0]  = mkVec(1, 1, 0, 0, 1, 1, 0, 0);
    vecs[1]  = mkVec(1, 1, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mkVec(1, 1, 0, 0, 0, 0, 2, 0);
    vecs[3]  = mkVec(1, 1, 0, 0, 0, 0, 3, 0);
    vecs[4]  = mkVec(1, 0, 0, 0, 0, 0, 4, 0);
    vecs[5]  = mkVec(1, 0, 1, 0, 0, 0, 5, 0);
    vecs[6]  = mkVec(1, 0, 1, 0, 0, 0, 6, 0);
    vecs[7]  = mkVec(1, 0, 0, 0, 0, 0, 7, 0);
    vecs[8]  = mkVec(1, 1, 0, 0, 1, 0, 0, 1);
    vecs[9]  = mkVec(0, 1, 0, 0, 1, 0, 0, 1);
    vecs[10] = mkVec(0, 1, 0, 0, 1, 0, 0, 1);
    vecs[11] = mkVec(1, 1, 0, 0, 0, 0, 1, 1);

    resetn = 1'b0;
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkAll("reset");
    checkOutput("reset_const_small", getS(), '0);
    checkOutput("reset_const_neg", getN(), mkExp(0, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    en = 1'b0;
    resetn = 1'b1;
    k = 0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en);
      checkOutput($sformatf("table%0d_small", i), getS(), vecs[i].e);
      e_n = vecs[i].e;
      e_n.hs = ~e_n.hs;
      e_n.vs = ~e_n.vs;
      checkOutput($sformatf("table%0d_neg", i), getN(), e_n);
    end

    doReset();
    den_cnt = 0; hs_pulses = 0; fs_cnt = 0; vs_high = 0; vs_first = -1;
    n_hs_low = 0; n_vs_low = 0; prev_hs = 1'b0;
    for (int i = 1; i <= 48; i++) begin
      applyStimulus(1'b1);
      if (if_s.den) den_cnt++;
      if (if_s.hsync && !prev_hs) hs_pulses++;
      prev_hs = if_s.hsync;
      if (if_s.frame_start) fs_cnt++;
      if (if_s.vsync) begin
        vs_high++;
        if (vs_first < 0) vs_first = i;
      end
      if (!if_n.hsync) n_hs_low++;
      if (!if_n.vsync) n_vs_low++;
    end
    checkCount("frame_den_cycles", den_cnt, 12);
    checkCount("frame_hsync_pulses", hs_pulses, 6);
    checkCount("frame_start_count", fs_cnt, 1);
    checkCount("frame_vsync_cycles", vs_high, 8);
    checkCount("frame_vsync_first_clock", vs_first, 33);
    checkCount("neg_hsync_low_cycles", n_hs_low, 12);
    checkCount("neg_vsync_low_cycles", n_vs_low, 8);
    applyStimulus(1'b1);
    checkOutput("frame_start_clock49", getS(), mkExp(1, 0, 0, 1, 1, 0, 0));

    doReset();
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(logic'($urandom_range(0, 3) != 0));
      checkAll("rand");
      if ($urandom_range(0, 299) == 0) asyncReset("rand_async_reset");
    end

    doReset();
    hs_720 = 0;
    for (int i = 0; i < 1280; i++) begin
      applyStimulus(1'b1);
      checkAll("line0");
      if (if_720.hsync) hs_720++;
    end
    checkOutput("pre_stall_720", get720(), mkExp(1, 0, 0, 0, 0, 1279, 0));
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0);
      checkOutput("stall_hold_720", get720(), mkExp(1, 0, 0, 0, 0, 1279, 0));
      checkAll("stall");
    end
    applyStimulus(1'b1);
    checkOutput("resume_den_fall_720", get720(), mkExp(0, 0, 0, 0, 0, 1280, 0));
    for (int i = 0; i < 2100; i++) begin
      applyStimulus(1'b1);
      checkAll("line1");
      if (k <= 1650 && if_720.hsync) hs_720++;
    end
    checkCount("hsync_width_720", hs_720, 40);

    doReset();
    repeat (20) applyStimulus(1'b1);
    #2;
    resetn = 1'b0;
    #1;
    k = 0;
    checkOutput("midframe_reset_small", getS(), '0);
    checkOutput("midframe_reset_neg", getN(), mkExp(0, 1, 1, 0, 0, 0, 0));
    checkOutput("midframe_reset_720", get720(), '0);
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b0;
    applyStimulus(1'b1);
    checkOutput("post_reset_first_small", getS(), mkExp(1, 0, 0, 1, 1, 0, 0));
    checkOutput("post_reset_first_720", get720(), mkExp(1, 0, 0, 1, 1, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
